// File: rtl/cpc_bus_pkg.sv
// Shared encodings for the CPC expansion-bus master: command types, T-states,
// ROM window limits and refresh counter width.
package cpc_bus_pkg;

  typedef enum logic [1:0] {
    CMD_MEM_RD = 2'b00,
    CMD_MEM_WR = 2'b01,
    CMD_IO_RD  = 2'b10,
    CMD_IO_WR  = 2'b11
  } cmd_type_e;

  typedef enum logic [2:0] {
    TS_IDLE,
    TS_T1,
    TS_T2,
    TS_TWA,
    TS_TW,
    TS_T3,
    TS_T4,
    TS_TO
  } tstate_e;

  localparam logic [15:0] LOWER_ROM_TOP  = 16'h3FFF;
  localparam logic [15:0] UPPER_ROM_BASE = 16'hC000;
  localparam int          REFRESH_W      = 7;

endpackage

// File: rtl/cpc_z80_bus_master_if.sv
// Command/response handshake plus the Z80-style expansion-connector bus,
// seen from the master (bus-cycle generator) and the slave (host/peripheral) side.
interface cpc_z80_bus_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic        cmd_m1;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        lower_rom_en;
  logic        upper_rom_en;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        rsp_romdis;
  logic [15:0] A;
  logic [7:0]  D_in;
  logic [7:0]  D_out;
  logic        D_oe;
  logic        MREQ_B;
  logic        IOREQ_B;
  logic        RD_B;
  logic        WR_B;
  logic        M1_B;
  logic        RFSH_B;
  logic        ROMEN_B;
  logic        READY;
  logic        ROMDIS;

  modport master (
    input  cmd_valid, cmd_type, cmd_m1, cmd_addr, cmd_wdata,
    input  lower_rom_en, upper_rom_en, D_in, READY, ROMDIS,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_romdis,
    output A, D_out, D_oe, MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B, ROMEN_B
  );

  modport slave (
    output cmd_valid, cmd_type, cmd_m1, cmd_addr, cmd_wdata,
    output lower_rom_en, upper_rom_en, D_in, READY, ROMDIS,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_romdis,
    input  A, D_out, D_oe, MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B, ROMEN_B
  );
endinterface

// File: rtl/cpc_romen_decode.sv
// Gate-Array style ROMEN_B qualifier: asserted only inside a memory-read strobe
// window that hits an enabled ROM bank, and released at once by ROMDIS.
module cpc_romen_decode
  import cpc_bus_pkg::*;
(
  input  logic [15:0] addr_i,
  input  logic        lower_en_i,
  input  logic        upper_en_i,
  input  logic        rd_window_i,
  input  logic        romdis_i,
  output logic        romen_b_o
);
  logic lowerHit;
  logic upperHit;

  assign lowerHit  = (addr_i <= LOWER_ROM_TOP) && lower_en_i;
  assign upperHit  = (addr_i >= UPPER_ROM_BASE) && upper_en_i;
  assign romen_b_o = !(rd_window_i && !romdis_i && (lowerHit || upperHit));
endmodule

// File: rtl/cpc_z80_bus_master.sv
// Z80-style bus-cycle generator: turns accepted commands into T-state accurate
// memory, opcode-fetch and IO cycles and returns one response per cycle.
module cpc_z80_bus_master #(
  parameter int IO_WAIT  = 1,
  parameter int MAX_WAIT = 15
) (
  input  logic                 CLK,
  input  logic                 RESET_B,
  cpc_z80_bus_master_if.master bus
);
  import cpc_bus_pkg::*;

  tstate_e              state_q, state_d;
  logic                 alive_q;
  logic [1:0]           type_q, type_d;
  logic                 fetch_q, fetch_d;
  logic [15:0]          addr_q, addr_d;
  logic [7:0]           wdata_q, wdata_d;
  logic                 lower_q, lower_d, upper_q, upper_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [REFRESH_W-1:0] r_q, r_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 romdis_q, romdis_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;

  logic cmdReady, isRead, isWrite, isIo;
  logic sampleReady, enterT3;
  logic inAccess, memRdWindow;
  logic mreqB, ioreqB, rdB, wrB, m1B, rfshB, romenB, doe;
  logic [15:0] aOut;

  // alive_q holds cmd_ready low for the first edge after reset is released
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state_q     <= TS_IDLE;
      alive_q     <= 1'b0;
      type_q      <= 2'b00;
      fetch_q     <= 1'b0;
      addr_q      <= 16'h0000;
      wdata_q     <= 8'h00;
      lower_q     <= 1'b0;
      upper_q     <= 1'b0;
      cnt_q       <= 8'h00;
      r_q         <= '0;
      rdata_q     <= 8'h00;
      romdis_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      alive_q     <= 1'b1;
      type_q      <= type_d;
      fetch_q     <= fetch_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lower_q     <= lower_d;
      upper_q     <= upper_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      rdata_q     <= rdata_d;
      romdis_q    <= romdis_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmdReady = (state_q == TS_IDLE) && alive_q;
  assign isRead   = (type_q == CMD_MEM_RD) || (type_q == CMD_IO_RD);
  assign isWrite  = (type_q == CMD_MEM_WR) || (type_q == CMD_IO_WR);
  assign isIo     = (type_q == CMD_IO_RD) || (type_q == CMD_IO_WR);

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    fetch_d     = fetch_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lower_d     = lower_q;
    upper_d     = upper_q;
    cnt_d       = cnt_q;
    r_d         = r_q;
    rdata_d     = rdata_q;
    romdis_d    = romdis_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    sampleReady = 1'b0;
    enterT3     = 1'b0;
    case (state_q)
      TS_IDLE: if (bus.cmd_valid && cmdReady) begin
        state_d = TS_T1;
        type_d  = bus.cmd_type;
        fetch_d = bus.cmd_m1 && (bus.cmd_type == CMD_MEM_RD);
        addr_d  = bus.cmd_addr;
        wdata_d = bus.cmd_wdata;
        lower_d = bus.lower_rom_en;
        upper_d = bus.upper_rom_en;
      end
      TS_T1: state_d = TS_T2;
      TS_T2: begin
        if (isIo && (IO_WAIT > 0)) begin
          state_d = TS_TWA;
          cnt_d   = 8'h00;
        end else begin
          sampleReady = 1'b1;
        end
      end
      TS_TWA: begin
        if (cnt_q == 8'(IO_WAIT - 1)) sampleReady = 1'b1;
        else                          cnt_d = cnt_q + 8'd1;
      end
      TS_TW: begin
        if (bus.READY)                          enterT3 = 1'b1;
        else if (cnt_q == 8'(MAX_WAIT - 1))     state_d = TS_TO;
        else                                    cnt_d = cnt_q + 8'd1;
      end
      TS_T3: begin
        if (fetch_q) begin
          state_d = TS_T4;
        end else begin
          state_d     = TS_IDLE;
          rdata_d     = isRead ? bus.D_in : 8'h00;
          romdis_d    = bus.ROMDIS;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
        end
      end
      TS_T4: begin
        state_d     = TS_IDLE;
        r_d         = r_q + 1'b1;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
      end
      default: begin
        state_d     = TS_IDLE;
        rdata_d     = 8'h00;
        romdis_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
      end
    endcase
    if (sampleReady) begin
      if (bus.READY) begin
        enterT3 = 1'b1;
      end else begin
        state_d = TS_TW;
        cnt_d   = 8'h00;
      end
    end
    // Opcode data is taken on the edge that leaves the last T2/TW
    if (enterT3) begin
      state_d = TS_T3;
      if (fetch_q) begin
        rdata_d  = bus.D_in;
        romdis_d = bus.ROMDIS;
      end
    end
  end

  always_comb begin
    inAccess = state_q inside {TS_T2, TS_TWA, TS_TW, TS_T3};
    aOut     = 16'h0000;
    mreqB    = 1'b1;
    ioreqB   = 1'b1;
    rdB      = 1'b1;
    wrB      = 1'b1;
    m1B      = 1'b1;
    rfshB    = 1'b1;
    doe      = 1'b0;
    if (state_q != TS_IDLE && state_q != TS_TO)
      aOut = (fetch_q && (state_q inside {TS_T3, TS_T4})) ? {8'h00, 1'b0, r_q} : addr_q;
    // Fetch T3/T4 is the refresh slot: MREQ drops again only in T4
    if (fetch_q) begin
      mreqB = !(state_q inside {TS_T2, TS_TW, TS_T4});
      rdB   = !(state_q inside {TS_T2, TS_TW});
      m1B   = !(state_q inside {TS_T1, TS_T2, TS_TW});
      rfshB = !(state_q inside {TS_T3, TS_T4});
    end else begin
      mreqB  = !(inAccess && !isIo);
      ioreqB = !(inAccess && isIo);
      rdB    = !(inAccess && isRead);
      wrB    = !(inAccess && isWrite);
      doe    = isWrite && (inAccess || state_q == TS_T1);
    end
  end

  assign memRdWindow = (type_q == CMD_MEM_RD) && !rdB;

  cpc_romen_decode u_romen (
    .addr_i      (addr_q),
    .lower_en_i  (lower_q),
    .upper_en_i  (upper_q),
    .rd_window_i (memRdWindow),
    .romdis_i    (bus.ROMDIS),
    .romen_b_o   (romenB)
  );

  assign bus.cmd_ready  = cmdReady;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rdata_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_romdis = romdis_q;
  assign bus.A          = aOut;
  assign bus.D_out      = doe ? wdata_q : 8'h00;
  assign bus.D_oe       = doe;
  assign bus.MREQ_B     = mreqB;
  assign bus.IOREQ_B    = ioreqB;
  assign bus.RD_B       = rdB;
  assign bus.WR_B       = wrB;
  assign bus.M1_B       = m1B;
  assign bus.RFSH_B     = rfshB;
  assign bus.ROMEN_B    = romenB;
endmodule

// File: tb/tb_cpc_z80_bus_master.sv
// Directed bench for cpc_z80_bus_master: table of bus cycles with hand-computed
// strobe counts, plus sequences for ROMDIS release, mid-cycle reset and R wrap.
module tb_cpc_z80_bus_master;

  typedef struct {
    logic [1:0]  cmdType;
    logic        m1;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        lowerEn;
    logic        upperEn;
    logic [7:0]  dIn;
    logic        romdis;
    int          readyLow;
    int          expCycles;
    int          expMreq;
    int          expIoreq;
    int          expRd;
    int          expWr;
    int          expOe;
    int          expM1;
    int          expRfsh;
    int          expRomen;
    int          expRdata;
    int          expRomdis;
    int          expErr;
  } vec_t;

  logic clk;
  logic resetB;
  int   assertCount;
  int   failCount;
  logic [6:0] rExp;
  vec_t vecs[15];
  vec_t f;

  cpc_z80_bus_master_if busIf();

  cpc_z80_bus_master #(.IO_WAIT(1), .MAX_WAIT(15)) dut (
    .CLK     (clk),
    .RESET_B (resetB),
    .bus     (busIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic startCmd(input vec_t v);
    int guard;
    guard = 0;
    while (!busIf.cmd_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("cmdReadyBeforeIssue", busIf.cmd_ready, 1);
    busIf.cmd_type     = v.cmdType;
    busIf.cmd_m1       = v.m1;
    busIf.cmd_addr     = v.addr;
    busIf.cmd_wdata    = v.wdata;
    busIf.lower_rom_en = v.lowerEn;
    busIf.upper_rom_en = v.upperEn;
    busIf.D_in         = v.dIn;
    busIf.ROMDIS       = v.romdis;
    busIf.cmd_valid    = 1'b1;
    @(posedge clk); #1;
    busIf.cmd_valid = 1'b0;
    checkOutput("cmdReadyDrop", busIf.cmd_ready, 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    int idx, cMreq, cIoreq, cRd, cWr, cOe, cM1, cRfsh, cRomen, doutBad;
    logic [15:0] firstA, refA;
    logic gotRefresh;
    idx = 0; cMreq = 0; cIoreq = 0; cRd = 0; cWr = 0; cOe = 0;
    cM1 = 0; cRfsh = 0; cRomen = 0; doutBad = 0;
    firstA = 16'h0; refA = 16'h0; gotRefresh = 1'b0;
    startCmd(v);
    while (!busIf.rsp_valid && idx < 40) begin
      busIf.READY = (idx < v.readyLow) ? 1'b0 : 1'b1;
      if (idx == 0) firstA = busIf.A;
      if (!busIf.MREQ_B)  cMreq++;
      if (!busIf.IOREQ_B) cIoreq++;
      if (!busIf.RD_B)    cRd++;
      if (!busIf.WR_B)    cWr++;
      if (busIf.D_oe)     cOe++;
      if (!busIf.M1_B)    cM1++;
      if (!busIf.RFSH_B)  cRfsh++;
      if (!busIf.ROMEN_B) cRomen++;
      if (!busIf.RFSH_B && !gotRefresh) begin
        refA = busIf.A;
        gotRefresh = 1'b1;
      end
      if (busIf.D_oe && busIf.D_out != v.wdata) doutBad++;
      @(posedge clk); #1;
      idx++;
    end
    busIf.READY = 1'b1;
    checkOutput("rspValid", busIf.rsp_valid, 1);
    checkOutput("tStates", idx, v.expCycles);
    checkOutput("addrT1", firstA, v.addr);
    checkOutput("mreqLow", cMreq, v.expMreq);
    checkOutput("ioreqLow", cIoreq, v.expIoreq);
    checkOutput("rdLow", cRd, v.expRd);
    checkOutput("wrLow", cWr, v.expWr);
    checkOutput("doeHigh", cOe, v.expOe);
    if (v.expM1 >= 0) checkOutput("m1Low", cM1, v.expM1);
    checkOutput("rfshLow", cRfsh, v.expRfsh);
    checkOutput("romenLow", cRomen, v.expRomen);
    checkOutput("doutValue", doutBad, 0);
    checkOutput("rspRdata", busIf.rsp_rdata, v.expRdata);
    if (v.expRomdis >= 0) checkOutput("rspRomdis", busIf.rsp_romdis, v.expRomdis);
    checkOutput("rspErr", busIf.rsp_err, v.expErr);
    checkOutput("idleStrobes", {busIf.MREQ_B, busIf.IOREQ_B, busIf.RD_B, busIf.WR_B,
                                busIf.M1_B, busIf.RFSH_B, busIf.ROMEN_B}, 7'h7F);
    if (v.cmdType == 2'b00 && v.m1 && v.expErr == 0) begin
      checkOutput("refreshAddr", refA, {9'b0, rExp});
      rExp = rExp + 7'd1;
    end
  endtask

  initial begin
    int guard;
    assertCount = 0;
    failCount   = 0;
    rExp        = 7'd0;
    resetB      = 1'b0;
    busIf.cmd_valid = 1'b0; busIf.cmd_type = 2'b00; busIf.cmd_m1 = 1'b0;
    busIf.cmd_addr = 16'h0; busIf.cmd_wdata = 8'h0; busIf.lower_rom_en = 1'b0;
    busIf.upper_rom_en = 1'b0; busIf.D_in = 8'h0; busIf.READY = 1'b1; busIf.ROMDIS = 1'b0;

    //            type  m1   addr      wd     lo    up    din    rd   rl  cyc mq io rd wr oe m1 rf ro rdata  rds err
    vecs[0]  = '{2'b00,1'b0,16'h0123,8'h00,1'b1,1'b0,8'hA5,1'b0, 0,  3, 2, 0, 2, 0, 0, 0, 0, 2, 'hA5,  0, 0};
    vecs[1]  = '{2'b11,1'b0,16'hDF05,8'h05,1'b1,1'b1,8'h00,1'b0, 0,  4, 0, 3, 0, 3, 4, 0, 0, 0, 'h00, -1, 0};
    vecs[2]  = '{2'b00,1'b1,16'hC000,8'h00,1'b0,1'b1,8'h3E,1'b1, 0,  4, 2, 0, 1, 0, 0, 2, 2, 0, 'h3E,  1, 0};
    vecs[3]  = '{2'b01,1'b0,16'h8000,8'h5A,1'b1,1'b1,8'h00,1'b0, 0,  3, 2, 0, 0, 2, 3, 0, 0, 0, 'h00, -1, 0};
    vecs[4]  = '{2'b10,1'b0,16'h7F00,8'h00,1'b1,1'b1,8'h42,1'b0, 0,  4, 0, 3, 3, 0, 0, 0, 0, 0, 'h42,  0, 0};
    vecs[5]  = '{2'b00,1'b0,16'hFFFF,8'h00,1'b0,1'b1,8'h99,1'b0, 0,  3, 2, 0, 2, 0, 0, 0, 0, 2, 'h99,  0, 0};
    vecs[6]  = '{2'b00,1'b0,16'h4000,8'h00,1'b1,1'b1,8'h11,1'b0, 0,  3, 2, 0, 2, 0, 0, 0, 0, 0, 'h11,  0, 0};
    vecs[7]  = '{2'b00,1'b0,16'h3FFF,8'h00,1'b0,1'b1,8'h22,1'b0, 0,  3, 2, 0, 2, 0, 0, 0, 0, 0, 'h22,  0, 0};
    vecs[8]  = '{2'b00,1'b1,16'h0038,8'h00,1'b1,1'b0,8'hC9,1'b0, 0,  4, 2, 0, 1, 0, 0, 2, 2, 1, 'hC9,  0, 0};
    vecs[9]  = '{2'b00,1'b0,16'h3FFF,8'h00,1'b1,1'b0,8'h33,1'b1, 0,  3, 2, 0, 2, 0, 0, 0, 0, 0, 'h33,  1, 0};
    vecs[10] = '{2'b01,1'b1,16'h0010,8'h77,1'b1,1'b0,8'h00,1'b0, 0,  3, 2, 0, 0, 2, 3, 0, 0, 0, 'h00, -1, 0};
    vecs[11] = '{2'b00,1'b1,16'h0000,8'h00,1'b1,1'b0,8'hED,1'b0, 3,  6, 4, 0, 3, 0, 0,-1, 2, 3, 'hED,  0, 0};
    vecs[12] = '{2'b10,1'b0,16'h1234,8'h00,1'b0,1'b0,8'h5C,1'b0, 3,  5, 0, 4, 4, 0, 0, 0, 0, 0, 'h5C,  0, 0};
    vecs[13] = '{2'b00,1'b0,16'h0010,8'h00,1'b1,1'b0,8'h66,1'b0,99, 18,16, 0,16, 0, 0, 0, 0,16, 'h00, -1, 1};
    vecs[14] = '{2'b00,1'b0,16'h8001,8'h00,1'b1,1'b1,8'h5A,1'b0, 0,  3, 2, 0, 2, 0, 0, 0, 0, 0, 'h5A,  0, 0};

    // Reset values while RESET_B is low
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstStrobes", {busIf.MREQ_B, busIf.IOREQ_B, busIf.RD_B, busIf.WR_B,
                               busIf.M1_B, busIf.RFSH_B, busIf.ROMEN_B}, 7'h7F);
    checkOutput("rstAddr", busIf.A, 16'h0000);
    checkOutput("rstDoe", busIf.D_oe, 0);
    checkOutput("rstDout", busIf.D_out, 8'h00);
    checkOutput("rstRspValid", busIf.rsp_valid, 0);
    checkOutput("rstRspErr", busIf.rsp_err, 0);
    checkOutput("rstCmdReady", busIf.cmd_ready, 0);
    resetB = 1'b1;
    #1;
    checkOutput("cmdReadyAtRelease", busIf.cmd_ready, 0);
    @(posedge clk); #1;
    checkOutput("cmdReadyAfterRelease", busIf.cmd_ready, 1);

    for (int i = 0; i < 15; i++) applyStimulus(vecs[i]);

    // ROMDIS rising inside the read strobe releases ROMEN_B immediately
    f = '{2'b00,1'b0,16'h0100,8'h00,1'b1,1'b0,8'h44,1'b0,0, 3,2,0,2,0,0,0,0,2,'h44,1,0};
    startCmd(f);
    @(posedge clk); #1;
    checkOutput("romenInT2", busIf.ROMEN_B, 0);
    busIf.ROMDIS = 1'b1;
    #1;
    checkOutput("romenReleased", busIf.ROMEN_B, 1);
    guard = 0;
    while (!busIf.rsp_valid && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("romdisRspValid", busIf.rsp_valid, 1);
    checkOutput("romdisRspFlag", busIf.rsp_romdis, 1);
    checkOutput("romdisRspData", busIf.rsp_rdata, 8'h44);
    busIf.ROMDIS = 1'b0;

    // Reset during TW of an IO read
    f = '{2'b10,1'b0,16'h2000,8'h00,1'b0,1'b0,8'h00,1'b0,99, 0,0,0,0,0,0,0,0,0,0,0,0};
    startCmd(f);
    busIf.READY = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("ioreqInTw", busIf.IOREQ_B, 0);
    checkOutput("rdInTw", busIf.RD_B, 0);
    #2 resetB = 1'b0;
    #1;
    checkOutput("midRstStrobes", {busIf.MREQ_B, busIf.IOREQ_B, busIf.RD_B, busIf.WR_B,
                                  busIf.M1_B, busIf.RFSH_B, busIf.ROMEN_B}, 7'h7F);
    checkOutput("midRstAddr", busIf.A, 16'h0000);
    checkOutput("midRstCmdReady", busIf.cmd_ready, 0);
    @(posedge clk); #1;
    checkOutput("midRstNoRsp", busIf.rsp_valid, 0);
    resetB = 1'b1;
    busIf.READY = 1'b1;
    rExp = 7'd0;
    #1;
    checkOutput("midRstReadyLow", busIf.cmd_ready, 0);
    @(posedge clk); #1;
    checkOutput("midRstReadyHigh", busIf.cmd_ready, 1);
    checkOutput("midRstNoRspAfter", busIf.rsp_valid, 0);

    // 130 fetches from R=0 walk the refresh counter through its 127->0 wrap
    f = '{2'b00,1'b1,16'h1000,8'h00,1'b0,1'b0,8'h00,1'b0,0, 4,2,0,1,0,0,2,2,0,0,0,0};
    for (int i = 0; i < 130; i++) begin
      f.dIn      = 8'(i * 3 + 1);
      f.expRdata = (i * 3 + 1) & 255;
      applyStimulus(f);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/cpc_z80_bus_master.md
Name: cpc_z80_bus_master

Overview:
- Initiator end of the CPC expansion-connector protocol: a Z80-style bus-cycle generator.
- Turns queued commands into T-state-accurate memory, opcode-fetch and IO cycles on A/D/MREQ_B/IOREQ_B/RD_B/WR_B/M1_B/RFSH_B, and drives ROMEN_B the way the Gate Array does.
- Used as the host-side driver in board bring-up and in simulation against our ROM/RAM expansion CPLDs; samples READY, ROMDIS and read data.

Parameters:
- IO_WAIT, 1, automatic wait states inserted after T2 of IO cycles (0..3).
- MAX_WAIT, 15, READY-low wait states tolerated before the cycle aborts with rsp_err.

Ports:
- CLK  in  1  T-state clock, rising edge.
- RESET_B  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_type  in  2  00 mem read, 01 mem write, 10 IO read, 11 IO write.
- cmd_m1  in  1  opcode fetch; valid only with type 00.
- cmd_addr  in  16  cycle address.
- cmd_wdata  in  8  write data.
- lower_rom_en  in  1  lower ROM (0x0000-0x3FFF) mapped; sampled at accept.
- upper_rom_en  in  1  upper ROM (0xC000-0xFFFF) mapped; sampled at accept.
- rsp_valid  out  1  one-cycle pulse at end of each cycle.
- rsp_rdata  out  8  read data; 0x00 for writes.
- rsp_err  out  1  wait timeout flag, valid with rsp_valid.
- rsp_romdis  out  1  ROMDIS as sampled with the data.
- A  out  16  address bus.
- D_in  in  8  data bus input.
- D_out  out  8  data bus output.
- D_oe  out  1  data bus output enable.
- MREQ_B, IOREQ_B, RD_B, WR_B, M1_B, RFSH_B, ROMEN_B  out  1 each  active-low strobes.
- READY  in  1  low requests wait states.
- ROMDIS  in  1  high disables internal ROM.

Behaviour:
- Reset (async, any state): all strobes 1, A=0x0000, D_oe=0, D_out=0x00, rsp_valid=0, rsp_err=0, cmd_ready=0 while RESET_B low, state IDLE, refresh counter R=0.
- Reset mid-cycle drops strobes immediately. No response is issued.
- Handshake: accept when cmd_valid & cmd_ready. Command fields are registered at accept. cmd_ready falls the next cycle.
- States: IDLE, T1, T2, TWA (automatic IO waits), TW, T3, T4 (M1 only), TO (timeout).
- Mem read/write: T1, T2, [TW]*, T3.
- IO: T1, T2, TWA x IO_WAIT, [TW]*, T3.
- Opcode fetch: T1, T2, [TW]*, T3, T4.
- A is driven from T1 to the last T-state.
- Read: MREQ_B or IOREQ_B low, and RD_B low, during T2..T3.
- Write: D_oe=1 with D_out=wdata from T1 through T3. WR_B low during T2..T3.
- Fetch: M1_B low during T1..T2. MREQ_B and RD_B low during T2 and TW.
- Fetch data: captured at the end of the last T2/TW, together with ROMDIS.
- Non-fetch read data: captured at the end of T3, together with ROMDIS.
- Fetch refresh (T3..T4): A={0x00,1'b0,R}, RFSH_B=0. MREQ_B is high in T3 and low in T4. R increments at the end of T4, 7-bit, wrapping 127 to 0.
- Wait states: READY sampled at the end of T2, or at the end of the last TWA for IO. READY=0 inserts TW; TW repeats while READY=0.
- Timeout: after MAX_WAIT consecutive TW with READY still 0, go to TO. In TO all strobes are high. Issue rsp_valid with rsp_err=1 and rsp_rdata=0x00, then return to IDLE.
- ROMEN_B: low exactly while RD_B is low on a memory read (fetch or not). Conditions: (A[15:14]==00 & lower_rom_en) or (A[15:14]==11 & upper_rom_en), and ROMDIS=0. Otherwise high. ROMDIS rising mid-cycle releases it combinationally.
- ROMEN_B is never asserted on writes, IO or refresh.
- Response: rsp_valid is one cycle, in the cycle after the last T-state; the FSM is in IDLE at that point. Back-to-back commands therefore have one idle T-state between bus cycles.
- cmd_m1 with a non-read type: treated as a plain cycle of that type, M1 ignored.

Decomposition:
- Package cpc_bus_pkg holds:
  - cmd_type encoding;
  - T-state enum;
  - LOWER_ROM_TOP=0x3FFF and UPPER_ROM_BASE=0xC000;
  - refresh width 7.
- One sub-module, cpc_romen_decode: combinational ROMEN_B qualifier from address, enables, strobe window and ROMDIS.

Test Plan:
- Mem read 0x0123, READY=1, D_in=0xA5, lower_rom_en=1 -> 3 T-states, ROMEN_B low during T2..T3, rsp_rdata=0xA5, rsp_romdis=0.
- IO write 0xDF05 data 0x05, IO_WAIT=1 -> IOREQ_B and WR_B low for 3 cycles (T2, TWA, T3), D_oe high for 4 cycles, MREQ_B and ROMEN_B stay high.
- Opcode fetch 0xC000, upper_rom_en=1, ROMDIS=1 -> M1_B low T1..T2, ROMEN_B stays high, refresh A=0x0000 then R=1 on the next fetch, rsp_romdis=1.
- Fetch with READY low for 2 samples -> exactly 2 TW inserted. 128 fetches -> R wraps to 0.
- READY held low -> 15 TW, then rsp_err=1 and rsp_rdata=0x00, strobes released.
- RESET_B low during TW of an IO read -> strobes high the same cycle, no rsp_valid, cmd_ready high one cycle after release.
